// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: the master drives the commands and the
// slave (the timer) returns count and status.
interface countdown_timer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned EVW   = 8
);
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic             clear;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [EVW-1:0]   ev_cnt;

    modport master (
        output start, load_val, en, auto_reload, clear,
        input  count, busy, done, ev_cnt
    );

    modport slave (
        input  start, load_val, en, auto_reload, clear,
        output count, busy, done, ev_cnt
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause, optional auto-reload and a wrapping expiry counter.
// DONE is a one-cycle state, so done is a single-cycle pulse on every expiry.
module countdown_timer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned EVW   = 8
) (
    input  logic               clk,
    input  logic               rst,
    countdown_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic [EVW-1:0]   r_ev_cnt;

    // Priority: clear, then start, then the per-state behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_ev_cnt <= '0;
        end else if (bus.clear) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else if (bus.start) begin
            r_reload <= bus.load_val;
            r_count  <= bus.load_val;
            if (bus.load_val != '0) begin
                r_state <= ST_RUN;
            end else begin
                r_state  <= ST_DONE;
                r_ev_cnt <= r_ev_cnt + EVW'(1);
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.en) begin
                        if (r_count > WIDTH'(1)) begin
                            r_count <= r_count - WIDTH'(1);
                        end else begin
                            r_count  <= '0;
                            r_state  <= ST_DONE;
                            r_ev_cnt <= r_ev_cnt + EVW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // A zero reload value never free-runs.
                    if (bus.auto_reload && (r_reload != '0)) begin
                        r_state <= ST_RUN;
                        r_count <= r_reload;
                    end else begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                    end
                end
                ST_IDLE: begin
                    r_count <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign bus.count  = r_count;
    assign bus.busy   = (r_state == ST_RUN);
    assign bus.done   = (r_state == ST_DONE);
    assign bus.ev_cnt = r_ev_cnt;

endmodule

// File: tb/tb_countdown_timer.sv
// Scenario bench for countdown_timer: each task pushes the expected observation for a
// cycle when it drives that cycle's stimulus, then pops and compares after the edge.
module tb_countdown_timer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned EVW   = 8;

    typedef struct packed {
        logic [WIDTH-1:0] count;
        logic             busy;
        logic             done;
        logic [EVW-1:0]   ev;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    countdown_timer_if #(.WIDTH(WIDTH), .EVW(EVW)) bus ();

    countdown_timer #(.WIDTH(WIDTH), .EVW(EVW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    obs_t           sb_q[$];
    int             n_cmp = 0;
    int             n_bad = 0;
    logic [EVW-1:0] ev_exp = '0;

    function automatic obs_t mk(input logic [WIDTH-1:0] c, input logic b, input logic d,
                                input logic [EVW-1:0] e);
        mk = {c, b, d, e};
    endfunction

    function automatic obs_t grab();
        grab = {bus.count, bus.busy, bus.done, bus.ev_cnt};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.start       = 1'b0;
        bus.load_val    = '0;
        bus.en          = 1'b0;
        bus.auto_reload = 1'b0;
        bus.clear       = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        ev_exp = '0;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        drive_idle();
        rst = 1'b1;
        sb_q.push_back(mk('0, 1'b0, 1'b0, '0));
        step();
        got = grab(); exp = sb_q.pop_front(); n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL reset: got cnt=%0d busy=%b done=%b ev=%0d, want cnt=%0d busy=%b done=%b ev=%0d",
                     got.count, got.busy, got.done, got.ev, exp.count, exp.busy, exp.done, exp.ev);
        end
        rst = 1'b0;
        ev_exp = '0;
        // en must not move anything while idle
        bus.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(mk('0, 1'b0, 1'b0, ev_exp));
            step();
            got = grab(); exp = sb_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL idle_en[%0d]: got cnt=%0d busy=%b done=%b ev=%0d, want cnt=%0d busy=%b done=%b ev=%0d",
                         i, got.count, got.busy, got.done, got.ev, exp.count, exp.busy, exp.done, exp.ev);
            end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_basic();
        obs_t got, exp;
        logic [WIDTH-1:0] c;
        logic b, d;
        drive_idle();
        bus.en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.start    = (i == 0);
            bus.load_val = (i == 0) ? WIDTH'(3) : '0;
            c = (i < 4) ? WIDTH'(3 - i) : '0;
            b = (i < 3);
            d = (i == 3);
            if (d) ev_exp++;
            sb_q.push_back(mk(c, b, d, ev_exp));
            step();
            got = grab(); exp = sb_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL basic[%0d]: got cnt=%0d busy=%b done=%b ev=%0d, want cnt=%0d busy=%b done=%b ev=%0d",
                         i, got.count, got.busy, got.done, got.ev, exp.count, exp.busy, exp.done, exp.ev);
            end
        end
    endtask

    task automatic test_pause();
        obs_t got, exp;
        logic [WIDTH-1:0] c;
        drive_idle();
        for (int i = 0; i < 10; i++) begin
            bus.start    = (i == 0);
            bus.load_val = (i == 0) ? WIDTH'(5) : '0;
            bus.en       = !(i >= 2 && i <= 4);
            case (i)
                0: c = 5;
                1, 2, 3, 4: c = 4;
                5: c = 3;
                6: c = 2;
                7: c = 1;
                default: c = 0;
            endcase
            if (i == 8) ev_exp++;
            sb_q.push_back(mk(c, (i < 8), (i == 8), ev_exp));
            step();
            got = grab(); exp = sb_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL pause[%0d]: got cnt=%0d busy=%b done=%b ev=%0d, want cnt=%0d busy=%b done=%b ev=%0d",
                         i, got.count, got.busy, got.done, got.ev, exp.count, exp.busy, exp.done, exp.ev);
            end
        end
    endtask

    task automatic test_auto_reload();
        obs_t got, exp;
        logic d;
        do_reset();
        bus.en          = 1'b1;
        bus.auto_reload = 1'b1;
        for (int i = 0; i < 13; i++) begin
            bus.start    = (i == 0);
            bus.load_val = (i == 0) ? WIDTH'(2) : '0;
            if (i == 12) begin
                bus.auto_reload = 1'b0;
                sb_q.push_back(mk('0, 1'b0, 1'b0, ev_exp));
            end else begin
                d = ((i % 3) == 2);
                if (d) ev_exp++;
                sb_q.push_back(mk(WIDTH'(2 - (i % 3)), !d, d, ev_exp));
            end
            step();
            got = grab(); exp = sb_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL auto[%0d]: got cnt=%0d busy=%b done=%b ev=%0d, want cnt=%0d busy=%b done=%b ev=%0d",
                         i, got.count, got.busy, got.done, got.ev, exp.count, exp.busy, exp.done, exp.ev);
            end
        end
        n_cmp++;
        if (bus.ev_cnt !== EVW'(4)) begin
            n_bad++;
            $display("FAIL auto_ev: got ev=%0d, want ev=4", bus.ev_cnt);
        end
    endtask

    task automatic test_priority();
        obs_t got, exp;
        logic [WIDTH-1:0] c;
        logic b;
        drive_idle();
        for (int i = 0; i < 7; i++) begin
            bus.start    = (i == 0) || (i == 2) || (i == 3);
            bus.load_val = (i == 0) ? WIDTH'(9) : WIDTH'(7);
            bus.clear    = (i == 2) || (i == 5);
            bus.en       = (i != 4);
            case (i)
                0: begin c = 9; b = 1'b1; end
                1: begin c = 8; b = 1'b1; end
                3, 4: begin c = 7; b = 1'b1; end
                default: begin c = 0; b = 1'b0; end
            endcase
            sb_q.push_back(mk(c, b, 1'b0, ev_exp));
            step();
            got = grab(); exp = sb_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL priority[%0d]: got cnt=%0d busy=%b done=%b ev=%0d, want cnt=%0d busy=%b done=%b ev=%0d",
                         i, got.count, got.busy, got.done, got.ev, exp.count, exp.busy, exp.done, exp.ev);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, exp;
        logic [WIDTH-1:0] c;
        logic d;
        drive_idle();
        bus.en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            bus.start    = (i == 0) || (i == 2) || (i == 9);
            bus.load_val = (i == 0) ? WIDTH'(4) : (i == 2) ? WIDTH'(6) : WIDTH'(2);
            case (i)
                0: c = 4;
                1: c = 3;
                2: c = 6;
                3, 4, 5, 6, 7: c = WIDTH'(8 - i);
                9: c = 2;
                10: c = 1;
                default: c = 0;
            endcase
            d = (i == 8) || (i == 11);
            if (d) ev_exp++;
            sb_q.push_back(mk(c, (c != 0), d, ev_exp));
            step();
            got = grab(); exp = sb_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got cnt=%0d busy=%b done=%b ev=%0d, want cnt=%0d busy=%b done=%b ev=%0d",
                         i, got.count, got.busy, got.done, got.ev, exp.count, exp.busy, exp.done, exp.ev);
            end
        end
    endtask

    task automatic test_zero_wrap();
        obs_t got, exp;
        do_reset();
        bus.en          = 1'b1;
        bus.auto_reload = 1'b1;
        for (int i = 0; i < 512; i++) begin
            bus.start    = ((i % 2) == 0);
            bus.load_val = '0;
            if ((i % 2) == 0) ev_exp++;
            sb_q.push_back(mk('0, 1'b0, ((i % 2) == 0), ev_exp));
            step();
            got = grab(); exp = sb_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL zero[%0d]: got cnt=%0d busy=%b done=%b ev=%0d, want cnt=%0d busy=%b done=%b ev=%0d",
                         i, got.count, got.busy, got.done, got.ev, exp.count, exp.busy, exp.done, exp.ev);
            end
        end
        n_cmp++;
        if (bus.ev_cnt !== '0) begin
            n_bad++;
            $display("FAIL ev_wrap: got ev=%0d, want ev=0", bus.ev_cnt);
        end
        bus.auto_reload = 1'b0;
    endtask

    task automatic test_async_reset();
        obs_t got, exp;
        do_reset();
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.start    = (i == 0);
            bus.load_val = (i == 0) ? WIDTH'(12) : '0;
            sb_q.push_back(mk(WIDTH'(12 - i), 1'b1, 1'b0, ev_exp));
            step();
            got = grab(); exp = sb_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL arst_run[%0d]: got cnt=%0d busy=%b done=%b ev=%0d, want cnt=%0d busy=%b done=%b ev=%0d",
                         i, got.count, got.busy, got.done, got.ev, exp.count, exp.busy, exp.done, exp.ev);
            end
        end
        // Reset lands mid-cycle; outputs must clear without a clock edge.
        #2;
        rst = 1'b1;
        ev_exp = '0;
        sb_q.push_back(mk('0, 1'b0, 1'b0, '0));
        #1;
        got = grab(); exp = sb_q.pop_front(); n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL arst_now: got cnt=%0d busy=%b done=%b ev=%0d, want cnt=%0d busy=%b done=%b ev=%0d",
                     got.count, got.busy, got.done, got.ev, exp.count, exp.busy, exp.done, exp.ev);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(mk('0, 1'b0, 1'b0, '0));
            step();
            got = grab(); exp = sb_q.pop_front(); n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL arst_after[%0d]: got cnt=%0d busy=%b done=%b ev=%0d, want cnt=%0d busy=%b done=%b ev=%0d",
                         i, got.count, got.busy, got.done, got.ev, exp.count, exp.busy, exp.done, exp.ev);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_auto_reload();
        test_priority();
        test_back_to_back();
        test_zero_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
